// File: rtl/core_loader.sv
// Operand loader and command sequencer for core_module: gathers 25 operand bytes onto flat
// buses, then runs one core operation per command with a done handshake and a timeout guard.
module core_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         clear_load,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_mode,
  output logic         cmd_ready,
  output logic [127:0] a_flat,
  output logic [71:0]  b_flat,
  output logic         active_send,
  output logic         active_single,
  output logic         active_sa3,
  output logic         active_sa2,
  input  logic         done_send,
  input  logic         done_single,
  input  logic         done_sa3,
  input  logic         done_sa2,
  output logic         op_done,
  output logic         timeout_err,
  output logic [1:0]   state_dbg
);

  // Handshakes: a byte transfers on a rising edge where in_valid && in_ready; a command
  // transfers on a rising edge where cmd_valid && cmd_ready. Ready never depends on valid.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [127:0]   a_q, a_d;
  logic [71:0]    b_q, b_d;
  logic [1:0]     mode_q, mode_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     active_q, active_d;
  logic           op_done_q, op_done_d;
  logic           timeout_err_q, timeout_err_d;
  logic           in_ready_q, in_ready_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic [3:0]     done_vec;
  logic           done_sel;

  assign done_vec = {done_sa2, done_sa3, done_single, done_send};
  assign done_sel = done_vec[mode_q];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    mode_d        = mode_q;
    timer_d       = timer_q;
    op_done_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          // Slots 16..24 land in B; cnt[3:0] is then already the B byte index.
          if (!cnt_q[4]) a_d[{cnt_q[3:0], 3'b000} +: 8] = in_data;
          else           b_d[{cnt_q[3:0], 3'b000} +: 8] = in_data;
          if (cnt_q == 5'd24) begin
            cnt_d   = 5'd0;
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_READY: begin
        if (clear_load) begin
          cnt_d   = 5'd0;
          state_d = S_LOAD;
        end else if (cmd_valid) begin
          mode_d  = cmd_mode;
          timer_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (done_sel) begin
          op_done_d = 1'b1;
          state_d   = S_READY;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_READY;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
    in_ready_d  = (state_d == S_LOAD);
    cmd_ready_d = (state_d == S_READY);
    active_d    = (state_d == S_RUN) ? (4'b0001 << mode_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      cnt_q         <= 5'd0;
      a_q           <= '0;
      b_q           <= '0;
      mode_q        <= 2'd0;
      timer_q       <= '0;
      active_q      <= 4'b0000;
      op_done_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      in_ready_q    <= 1'b1;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      mode_q        <= mode_d;
      timer_q       <= timer_d;
      active_q      <= active_d;
      op_done_q     <= op_done_d;
      timeout_err_q <= timeout_err_d;
      in_ready_q    <= in_ready_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign cmd_ready     = cmd_ready_q;
  assign a_flat        = a_q;
  assign b_flat        = b_q;
  assign active_send   = active_q[0];
  assign active_single = active_q[1];
  assign active_sa3    = active_q[2];
  assign active_sa2    = active_q[3];
  assign op_done       = op_done_q;
  assign timeout_err   = timeout_err_q;
  assign state_dbg     = state_q;

endmodule
